// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses a little-endian word count and words, writes them to instruction memory.
// Write strobe follows the 4th byte of each word by one cycle; all outputs registered; in_ready drops in FLUSH/DONE/ERR.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        restart,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_clrn,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, FLUSH, DONE, ERR} state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [31:0] asm_q, asm_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [15:0] words_q, words_d;
  logic        in_ready_q, in_ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cpu_clrn_q, cpu_clrn_d;
  logic        accept;
  logic [15:0] n_full;

  assign accept = in_valid && in_ready_q;
  assign n_full = {in_data, n_q[7:0]};

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    words_d    = words_q;

    case (state_q)
      LEN0: if (accept) begin
        n_d     = {8'h00, in_data};
        state_d = LEN1;
      end
      LEN1: if (accept) begin
        n_d        = n_full;
        byte_idx_d = 2'd0;
        word_idx_d = 16'd0;
        if (n_full == 16'd0)      state_d = DONE;
        else if (n_full > MAX_W)  state_d = ERR;
        else                      state_d = DATA;
      end
      DATA: if (accept) begin
        case (byte_idx_q)
          2'd0:    asm_d[7:0]   = in_data;
          2'd1:    asm_d[15:8]  = in_data;
          2'd2:    asm_d[23:16] = in_data;
          default: asm_d[31:24] = in_data;
        endcase
        if (byte_idx_q == 2'd3) begin
          wr_en_d    = 1'b1;
          wr_data_d  = {in_data, asm_q[23:0]};
          wr_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
          words_d    = words_q + 16'd1;
          byte_idx_d = 2'd0;
          if (word_idx_q == n_q - 16'd1) state_d = FLUSH;
          else                           word_idx_d = word_idx_q + 16'd1;
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      FLUSH: state_d = DONE;
      DONE, ERR: if (restart) begin
        state_d    = LEN0;
        words_d    = 16'd0;
        byte_idx_d = 2'd0;
        word_idx_d = 16'd0;
      end
      default: state_d = LEN0;
    endcase

    // Status flags are decoded from the next state so they register in step with it.
    in_ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
    done_d     = (state_d == DONE);
    cpu_clrn_d = (state_d == DONE);
    err_d      = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= LEN0;
      n_q        <= 16'd0;
      byte_idx_q <= 2'd0;
      word_idx_q <= 16'd0;
      asm_q      <= 32'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
      words_q    <= 16'd0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_clrn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      asm_q      <= asm_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      words_q    <= words_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_clrn_q <= cpu_clrn_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_clrn     = cpu_clrn_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table on a default instance plus sequences on a relocated instance.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr0 = 1'b0, v0 = 1'b0, rs0 = 1'b0;
  logic [7:0]  d0 = 8'h00;
  logic        rdy0, we0, clrn0, done0, err0;
  logic [31:0] addr0, data0;
  logic [15:0] words0;

  logic        clr1 = 1'b0, v1 = 1'b0, rs1 = 1'b0;
  logic [7:0]  d1 = 8'h00;
  logic        rdy1, we1, clrn1, done1, err1;
  logic [31:0] addr1, data1;
  logic [15:0] words1;

  imem_loader u0 (
    .clk(clk), .clr(clr0), .in_valid(v0), .in_data(d0), .in_ready(rdy0), .restart(rs0),
    .wr_en(we0), .wr_addr(addr0), .wr_data(data0), .cpu_clrn(clrn0), .done(done0),
    .err(err0), .words_loaded(words0)
  );

  imem_loader #(.BASE_ADDR(32'h0040_0000), .MAX_WORDS(64)) u1 (
    .clk(clk), .clr(clr1), .in_valid(v1), .in_data(d1), .in_ready(rdy1), .restart(rs1),
    .wr_en(we1), .wr_addr(addr1), .wr_data(data1), .cpu_clrn(clrn1), .done(done1),
    .err(err1), .words_loaded(words1)
  );

  typedef struct packed {
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        clrn;
    logic        done;
    logic        err;
    logic [15:0] words;
  } obs_t;

  typedef struct {
    logic       c;
    logic       v;
    logic [7:0] d;
    logic       r;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic c, input logic v, input logic [7:0] d, input logic r,
                     input logic rdy, input logic we, input logic [31:0] a, input logic [31:0] dt,
                     input logic clrn, input logic dn, input logic er, input logic [15:0] w);
    vec_t t;
    t.c = c; t.v = v; t.d = d; t.r = r;
    t.exp = '{rdy: rdy, we: we, addr: a, data: dt, clrn: clrn, done: dn, err: er, words: w};
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step0(input logic c, input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    clr0 = c; v0 = v; d0 = d; rs0 = r;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic c, input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    clr1 = c; v1 = v; d1 = d; rs1 = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    obs_t act;
    logic [7:0]  tb_bytes[6];
    logic [7:0]  rb_bytes[14];
    logic [31:0] cap_a[4];
    logic [31:0] cap_d[4];
    int          pulses;
    int          wait_cnt;

    //   c  v  d     r   rdy we addr          data          clrn done err words
    add(1, 0, 8'h00, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);  // reset
    add(0, 1, 8'h02, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'h00, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'h13, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'h00, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'h08, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'h20, 0,  1, 1, 32'h0,        32'h20080013, 0, 0, 0, 16'd1);
    add(0, 1, 8'h01, 0,  1, 0, 32'h0,        32'h20080013, 0, 0, 0, 16'd1);
    add(0, 1, 8'h00, 0,  1, 0, 32'h0,        32'h20080013, 0, 0, 0, 16'd1);
    add(0, 1, 8'h09, 0,  1, 0, 32'h0,        32'h20080013, 0, 0, 0, 16'd1);
    add(0, 1, 8'h20, 0,  0, 1, 32'h4,        32'h20090001, 0, 0, 0, 16'd2);  // FLUSH
    add(0, 0, 8'h00, 0,  0, 0, 32'h4,        32'h20090001, 1, 1, 0, 16'd2);  // DONE
    add(0, 1, 8'h55, 0,  0, 0, 32'h4,        32'h20090001, 1, 1, 0, 16'd2);
    add(0, 0, 8'h00, 1,  1, 0, 32'h4,        32'h20090001, 0, 0, 0, 16'd0);  // restart
    add(0, 1, 8'h00, 0,  1, 0, 32'h4,        32'h20090001, 0, 0, 0, 16'd0);
    add(0, 1, 8'h00, 0,  0, 0, 32'h4,        32'h20090001, 1, 1, 0, 16'd0);  // N=0
    add(0, 0, 8'h00, 1,  1, 0, 32'h4,        32'h20090001, 0, 0, 0, 16'd0);
    add(0, 1, 8'h41, 0,  1, 0, 32'h4,        32'h20090001, 0, 0, 0, 16'd0);
    add(0, 1, 8'h00, 0,  0, 0, 32'h4,        32'h20090001, 0, 0, 1, 16'd0);  // N=65 > 64
    add(0, 1, 8'h12, 0,  0, 0, 32'h4,        32'h20090001, 0, 0, 1, 16'd0);
    add(0, 1, 8'h12, 1,  1, 0, 32'h4,        32'h20090001, 0, 0, 0, 16'd0);
    add(0, 1, 8'h40, 0,  1, 0, 32'h4,        32'h20090001, 0, 0, 0, 16'd0);
    add(0, 1, 8'h00, 0,  1, 0, 32'h4,        32'h20090001, 0, 0, 0, 16'd0);  // N=64 ok
    add(0, 0, 8'h00, 1,  1, 0, 32'h4,        32'h20090001, 0, 0, 0, 16'd0);
    add(1, 0, 8'h00, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'h01, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'h00, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'hEF, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'hBE, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(1, 1, 8'hAD, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);  // clr mid-word
    add(0, 1, 8'h01, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'h00, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'hEF, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'hBE, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'hAD, 0,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    add(0, 1, 8'hDE, 0,  0, 1, 32'h0,        32'hDEADBEEF, 0, 0, 0, 16'd1);
    add(0, 0, 8'h00, 0,  0, 0, 32'h0,        32'hDEADBEEF, 1, 1, 0, 16'd1);
    add(1, 1, 8'h77, 1,  1, 0, 32'h0,        32'h0,        0, 0, 0, 16'd0);  // clr beats restart

    foreach (vecs[i]) begin
      step0(vecs[i].c, vecs[i].v, vecs[i].d, vecs[i].r);
      act = {rdy0, we0, addr0, data0, clrn0, done0, err0, words0};
      checks++;
      if (act !== vecs[i].exp) begin
        failures++;
        $display("FAIL vec%0d: got rdy=%b we=%b a=%h d=%h clrn=%b done=%b err=%b w=%0d expected rdy=%b we=%b a=%h d=%h clrn=%b done=%b err=%b w=%0d",
                 i, act.rdy, act.we, act.addr, act.data, act.clrn, act.done, act.err, act.words,
                 vecs[i].exp.rdy, vecs[i].exp.we, vecs[i].exp.addr, vecs[i].exp.data,
                 vecs[i].exp.clrn, vecs[i].exp.done, vecs[i].exp.err, vecs[i].exp.words);
      end
    end

    // One word with in_valid toggling; junk on in_data while invalid must be ignored.
    tb_bytes = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20};
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step0(0, 1, tb_bytes[i], 0);
      if (we0) begin
        if (pulses < 4) begin cap_a[pulses] = addr0; cap_d[pulses] = data0; end
        pulses++;
      end
      step0(0, 0, 8'hFF, 0);
      if (we0) begin
        if (pulses < 4) begin cap_a[pulses] = addr0; cap_d[pulses] = data0; end
        pulses++;
      end
    end
    wait_cnt = 0;
    while (!done0 && wait_cnt < 8) begin
      step0(0, 0, 8'h00, 0);
      if (we0) pulses++;
      wait_cnt++;
    end
    chk("toggle_pulses", 32'(pulses), 32'd1);
    chk("toggle_addr", cap_a[0], 32'h0);
    chk("toggle_data", cap_d[0], 32'h20080013);
    chk("toggle_done", {31'd0, done0}, 32'd1);
    chk("toggle_clrn", {31'd0, clrn0}, 32'd1);
    chk("toggle_words", {16'd0, words0}, 32'd1);

    // Relocated base, three words, then restart and a one-word reload.
    step1(1, 0, 8'h00, 0);
    chk("u1_reset_rdy", {31'd0, rdy1}, 32'd1);
    rb_bytes = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                 8'h09, 8'h0A, 8'h0B, 8'h0C};
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step1(0, 1, rb_bytes[i], 0);
      if (we1) begin
        if (pulses < 4) begin cap_a[pulses] = addr1; cap_d[pulses] = data1; end
        pulses++;
      end
    end
    step1(0, 0, 8'h00, 0);
    if (we1) pulses++;
    chk("base_pulses", 32'(pulses), 32'd3);
    chk("base_addr0", cap_a[0], 32'h0040_0000);
    chk("base_addr1", cap_a[1], 32'h0040_0004);
    chk("base_addr2", cap_a[2], 32'h0040_0008);
    chk("base_data2", cap_d[2], 32'h0C0B0A09);
    chk("base_done", {31'd0, done1}, 32'd1);
    chk("base_words", {16'd0, words1}, 32'd3);

    step1(0, 0, 8'h00, 1);
    chk("restart_words", {16'd0, words1}, 32'd0);
    chk("restart_clrn", {31'd0, clrn1}, 32'd0);
    rb_bytes[0:5] = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step1(0, 1, rb_bytes[i], 0);
      if (we1) begin cap_a[0] = addr1; cap_d[0] = data1; pulses++; end
    end
    chk("reload_pulses", 32'(pulses), 32'd1);
    chk("reload_addr", cap_a[0], 32'h0040_0000);
    chk("reload_data", cap_d[0], 32'hDDCCBBAA);
    chk("reload_words", {16'd0, words1}, 32'd1);
    step1(0, 0, 8'h00, 0);
    chk("reload_done", {31'd0, done1}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 64, instruction memory capacity in words; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 in_data  input  8  byte-stream payload.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 restart  input  1  one-cycle request to begin a new load; honoured only in DONE or ERR.
REQ-009 wr_en  output  1  instruction-memory write strobe.
REQ-010 wr_addr  output  32  instruction-memory byte address.
REQ-011 wr_data  output  32  instruction word to write.
REQ-012 cpu_clrn  output  1  active-low clear to the single-cycle computer; low holds the CPU in reset.
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  load rejected (length over capacity).
REQ-015 words_loaded  output  16  count of words written in the current load.

Function
REQ-016 States SHALL be LEN0, LEN1, DATA, FLUSH, DONE, ERR; all outputs SHALL be registered.
REQ-017 A byte SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in LEN0, LEN1, DATA.
REQ-018 Stream format: 16-bit word count N, little-endian (low byte first), then N words of 4 bytes each, little-endian.
REQ-019 LEN0: accepted byte -> N[7:0], go to LEN1.
REQ-020 LEN1: accepted byte -> N[15:8]; if N=0 go to DONE; if N>MAX_WORDS go to ERR; else go to DATA with byte index 0, word index 0.
REQ-021 DATA: each accepted byte SHALL fill bits [8k+7:8k] of the assembly register, k=byte index 0..3.
REQ-022 On acceptance of byte index 3, the following cycle SHALL have wr_en=1, wr_data=assembled word, wr_addr=BASE_ADDR+4*word index (32-bit, modulo 2^32); wr_en SHALL be high for exactly one cycle per word.
REQ-023 words_loaded SHALL increment by 1 on the same edge that asserts wr_en.
REQ-024 If the accepted byte completes word N-1, state SHALL go to FLUSH (in_ready=0), otherwise remain in DATA with byte index 0.
REQ-025 FLUSH SHALL last one cycle (the final wr_en cycle) then go to DONE.
REQ-026 DONE: done=1, cpu_clrn=1, err=0, wr_en=0; done/cpu_clrn SHALL rise one cycle after the last wr_en pulse, never coincident with it.
REQ-027 ERR: err=1, done=0, cpu_clrn=0, in_ready=0, no writes.
REQ-028 restart=1 in DONE or ERR SHALL on that edge go to LEN0, clear done, err, words_loaded, and drive cpu_clrn=0; restart in any other state SHALL be ignored.
REQ-029 In LEN0 through FLUSH, cpu_clrn SHALL be 0, done=0, err=0.
REQ-030 wr_addr/wr_data SHALL hold their last values when wr_en=0.
REQ-031 in_valid with in_ready=0 SHALL have no effect; bytes are never dropped while in_ready=1.

Reset
REQ-032 clr=1 SHALL on the next edge force LEN0, byte/word indices 0, wr_en=0, wr_addr=0, wr_data=0, words_loaded=0, done=0, err=0, cpu_clrn=0, in_ready=1 after release; clr SHALL override restart and in_valid.
REQ-033 clr asserted mid-load SHALL abandon the partial word with no further write; the next load starts from a fresh length field.

Verification
REQ-034 Stream 02 00 | 13 00 08 20 | 01 00 09 20, in_valid held 1 -> wr_en pulses with (0x0,0x20080013) then (0x4,0x20090001); done=1, cpu_clrn=1 one cycle after second pulse; words_loaded=2.
REQ-035 Stream 00 00 -> no wr_en; DONE entered on edge after second byte; done=1, cpu_clrn=1, words_loaded=0.
REQ-036 MAX_WORDS=64, stream 41 00 -> ERR; err=1, in_ready=0, cpu_clrn=0; further bytes ignored; restart -> LEN0, err=0.
REQ-037 Stream of one word with in_valid toggling 1/0 every cycle -> identical wr_addr/wr_data as continuous case; no duplicate or lost bytes.
REQ-038 clr asserted after 2 of 4 data bytes, then stream 01 00 EF BE AD DE -> single write (BASE_ADDR, 0xDEADBEEF), done=1.
REQ-039 BASE_ADDR=0x0040_0000, N=3 -> wr_addr 0x0040_0000, 0x0040_0004, 0x0040_0008; restart in DONE then reload N=1 -> words_loaded restarts at 1.
